apb_splitter_tmo: RTL
=====================

APB_SPLITTER_TMO -- requirements
Module: apb_splitter_tmo

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- W_ADDR, 16, address width.
- W_DATA, 32, data width.
- N_SLAVES, 3, downstream port count, 1..16.
- ADDR_MAP, 48'h4000_2000_0000, packed per-slave match values; slave i at [i*W_ADDR +: W_ADDR].
- ADDR_MASK, 48'he000_e000_e000, packed per-slave masks, same packing.
- TIMEOUT, 256, access-phase cycle limit; 0 disables.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock.
- rst, in, 1, reset, asynchronous, active-high.
- apbs_paddr / apbs_pwrite / apbs_pwdata, in, W_ADDR / 1 / W_DATA, upstream request.
- apbs_psel / apbs_penable, in, 1, upstream phase controls.
- apbs_phartid / apbs_pd_pc, in, W_DATA / 32, sideband.
- apbs_pready / apbs_pslverr, out, 1, upstream response.
- apbs_prdata, out, W_DATA, upstream read data.
- apbm_paddr / apbm_pwdata / apbm_hartid, out, N_SLAVES*W_ADDR / N_SLAVES*W_DATA / N_SLAVES*W_DATA, replicated registered request.
- apbm_pd_pc, out, N_SLAVES*32, replicated registered request.
- apbm_psel / apbm_penable / apbm_pwrite, out, N_SLAVES, per-slave controls.
- apbm_pready / apbm_pslverr, in, N_SLAVES, downstream response.
- apbm_prdata, in, N_SLAVES*W_DATA, downstream read data.
- tmo_count, out, 16, saturating count of timed-out accesses.

Function
REQ-003 SHALL decode slave i as a hit when (addr & mask_i) == map_i. When several slaves hit, the lowest index SHALL win, so the selection is strictly one-hot or zero.
REQ-004 SHALL implement the FSM states IDLE, SETUP, ACCESS, DECERR, RESP.
REQ-005 In IDLE, on apbs_psel=1 and apbs_penable=0, the block SHALL register paddr, pwrite, pwdata, phartid, pd_pc and the decoded one-hot select.
- On a hit it SHALL go to SETUP.
- On no hit it SHALL go to DECERR.
REQ-006 SETUP SHALL drive apbm_psel[k]=1 and apbm_penable[k]=0 for the selected k only, for exactly one cycle, then go to ACCESS.
REQ-007 ACCESS SHALL drive apbm_psel[k]=1 and apbm_penable[k]=1.
- On apbm_pready[k]=1 it SHALL capture apbm_prdata[k] and apbm_pslverr[k], then go to RESP.
REQ-008 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without pready.
- If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without pready, the block SHALL leave ACCESS for RESP with pslverr=1 and prdata=0.
- It SHALL increment tmo_count, saturating at 16'hFFFF.
REQ-009 DECERR SHALL last exactly one cycle, assert no apbm_psel, then go to RESP with pslverr=1 and prdata=0.
REQ-010 RESP SHALL assert apbs_pready=1 for exactly one cycle with the registered prdata and pslverr, then go to IDLE.
REQ-011 In every state other than RESP, the block SHALL hold apbs_pready=0, apbs_pslverr=0 and apbs_prdata=0.
REQ-012 Upstream signal changes outside IDLE SHALL be ignored; a captured transaction always completes.
REQ-013 apbm_paddr, apbm_pwdata, apbm_hartid and apbm_pd_pc SHALL be replicated from the registered copies and held stable from SETUP through ACCESS.
REQ-014 Latency for a zero-wait hit SHALL be: upstream setup at T0, apbs_pready at T3.
- Each downstream wait state SHALL add exactly one cycle.
- A decode error SHALL respond at T2.
REQ-015 apbm_pwrite[k] SHALL be asserted only with apbm_psel[k].

Reset
REQ-016 rst=1 SHALL asynchronously force:
- state=IDLE;
- all apbm_psel, apbm_penable, apbm_pwrite = 0;
- apbs_pready, apbs_pslverr, apbs_prdata = 0;
- wait counter = 0;
- tmo_count = 0;
- request registers = 0.
REQ-017 Reset asserted mid-transaction SHALL drop the downstream psel in the same cycle with no response upstream. The first capture after reset deassertion SHALL occur at the first clk edge with rst=0.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Read 0x2010, slave 1 pready=1 immediately, prdata=0xCAFEF00D -> only apbm_psel[1] asserted; apbs_pready at T3; prdata=0xCAFEF00D; pslverr=0.
- Write 0x0004 data 0x12345678, slave 0 holds pready=0 for 3 cycles -> apbs_pready at T6; apbm_pwdata slice 0 = 0x12345678 throughout; apbm_pwrite[0]=1.
- Access 0x8000 (no match) -> no apbm_psel at any point; apbs_pready at T2; pslverr=1; prdata=0.
- TIMEOUT=4, slave 2 never ready -> ACCESS lasts 4 cycles; pslverr=1; tmo_count 0->1; repeating this 0x10000 times leaves tmo_count at 0xFFFF.
- Overlapping maps with slaves 0 and 1 both matching -> only apbm_psel[0] is asserted.
- Assert rst during ACCESS -> apbm_psel=0 within the same cycle; the next transaction completes normally.

Source files
------------

// File: rtl/apb_splitter_tmo.sv
// APB 1-to-N splitter: lowest-index address decode, one-cycle decode-error response, access-phase timeout.
// Zero-wait hit answers 3 cycles after setup (+1 per slave wait state); upstream is ignored until RESP completes.
module apb_splitter_tmo #(
  parameter int W_ADDR   = 16,
  parameter int W_DATA   = 32,
  parameter int N_SLAVES = 3,
  parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MAP  = 48'h4000_2000_0000,
  parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MASK = 48'he000_e000_e000,
  parameter int TIMEOUT  = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W_ADDR-1:0]            apbs_paddr,
  input  logic                         apbs_pwrite,
  input  logic [W_DATA-1:0]            apbs_pwdata,
  input  logic                         apbs_psel,
  input  logic                         apbs_penable,
  input  logic [W_DATA-1:0]            apbs_phartid,
  input  logic [31:0]                  apbs_pd_pc,
  output logic                         apbs_pready,
  output logic                         apbs_pslverr,
  output logic [W_DATA-1:0]            apbs_prdata,
  output logic [N_SLAVES*W_ADDR-1:0]   apbm_paddr,
  output logic [N_SLAVES*W_DATA-1:0]   apbm_pwdata,
  output logic [N_SLAVES*W_DATA-1:0]   apbm_hartid,
  output logic [N_SLAVES*32-1:0]       apbm_pd_pc,
  output logic [N_SLAVES-1:0]          apbm_psel,
  output logic [N_SLAVES-1:0]          apbm_penable,
  output logic [N_SLAVES-1:0]          apbm_pwrite,
  input  logic [N_SLAVES-1:0]          apbm_pready,
  input  logic [N_SLAVES-1:0]          apbm_pslverr,
  input  logic [N_SLAVES*W_DATA-1:0]   apbm_prdata,
  output logic [15:0]                  tmo_count
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DECERR, RESP} state_t;

  localparam int W_CNT = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W_CNT-1:0] CNT_LAST = (TIMEOUT > 0) ? W_CNT'(TIMEOUT - 1) : '0;

  state_t                state_q, state_d;
  logic [W_ADDR-1:0]     addr_q, addr_d;
  logic                  write_q, write_d;
  logic [W_DATA-1:0]     wdata_q, wdata_d;
  logic [W_DATA-1:0]     hartid_q, hartid_d;
  logic [31:0]           pdpc_q, pdpc_d;
  logic [N_SLAVES-1:0]   sel_q, sel_d;
  logic [W_DATA-1:0]     rdata_q, rdata_d;
  logic                  slverr_q, slverr_d;
  logic [W_CNT-1:0]      wcnt_q, wcnt_d;
  logic [15:0]           tmo_q, tmo_d;

  logic [N_SLAVES-1:0]   hit_sel;
  logic                  hit_found;
  logic                  sel_pready;
  logic                  sel_pslverr;
  logic [W_DATA-1:0]     sel_prdata;

  // Priority decode: the first matching slave claims the address.
  always_comb begin
    hit_sel   = '0;
    hit_found = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!hit_found &&
          ((apbs_paddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR])) begin
        hit_sel[i] = 1'b1;
        hit_found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_pready  = |(apbm_pready & sel_q);
    sel_pslverr = |(apbm_pslverr & sel_q);
    sel_prdata  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) sel_prdata = sel_prdata | apbm_prdata[i*W_DATA +: W_DATA];
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    hartid_d = hartid_q;
    pdpc_d   = pdpc_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    wcnt_d   = wcnt_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (apbs_psel && !apbs_penable) begin
          addr_d   = apbs_paddr;
          write_d  = apbs_pwrite;
          wdata_d  = apbs_pwdata;
          hartid_d = apbs_phartid;
          pdpc_d   = apbs_pd_pc;
          sel_d    = hit_sel;
          rdata_d  = '0;
          slverr_d = 1'b0;
          state_d  = hit_found ? SETUP : DECERR;
        end
      end
      SETUP: begin
        wcnt_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (sel_pready) begin
          rdata_d  = sel_prdata;
          slverr_d = sel_pslverr;
          state_d  = RESP;
        end else if ((TIMEOUT != 0) && (wcnt_q == CNT_LAST)) begin
          rdata_d  = '0;
          slverr_d = 1'b1;
          tmo_d    = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
          state_d  = RESP;
        end else begin
          wcnt_d = wcnt_q + W_CNT'(1);
        end
      end
      DECERR: begin
        rdata_d  = '0;
        slverr_d = 1'b1;
        state_d  = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      hartid_q <= '0;
      pdpc_q   <= '0;
      sel_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      wcnt_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      hartid_q <= hartid_d;
      pdpc_q   <= pdpc_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      wcnt_q   <= wcnt_d;
      tmo_q    <= tmo_d;
    end
  end

  // Controls decode from state so an async reset drops psel immediately.
  assign apbm_psel    = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
  assign apbm_penable = (state_q == ACCESS) ? sel_q : '0;
  assign apbm_pwrite  = apbm_psel & {N_SLAVES{write_q}};
  assign apbm_paddr   = {N_SLAVES{addr_q}};
  assign apbm_pwdata  = {N_SLAVES{wdata_q}};
  assign apbm_hartid  = {N_SLAVES{hartid_q}};
  assign apbm_pd_pc   = {N_SLAVES{pdpc_q}};

  assign apbs_pready  = (state_q == RESP);
  assign apbs_pslverr = apbs_pready & slverr_q;
  assign apbs_prdata  = apbs_pready ? rdata_q : '0;
  assign tmo_count    = tmo_q;

endmodule
